// File: rtl/of_pkg.sv
// Shared types, default widths and the operand bypass select for the operand fetch stage.
package of_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] rs1;
        logic [DEF_ADDR_W-1:0] rs2;
        logic [DEF_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  is_long;
    } of_req_t;

    // Youngest producer wins; a nonzero src means rd==0 writers can never match.
    function automatic logic [DEF_DATA_W-1:0] bypass_sel(
        input logic [DEF_ADDR_W-1:0] src,
        input logic [DEF_DATA_W-1:0] rf_data,
        input logic                  ex_wen,
        input logic                  ex_load,
        input logic [DEF_ADDR_W-1:0] ex_rd,
        input logic [DEF_DATA_W-1:0] ex_data,
        input logic                  mem_wen,
        input logic [DEF_ADDR_W-1:0] mem_rd,
        input logic [DEF_DATA_W-1:0] mem_data,
        input logic                  wb_wen,
        input logic [DEF_ADDR_W-1:0] wb_rd,
        input logic [DEF_DATA_W-1:0] wb_data
    );
        logic [DEF_DATA_W-1:0] sel;
        sel = rf_data;
        if (src == REG_ZERO) begin
            sel = '0;
        end else if (ex_wen && !ex_load && (ex_rd == src)) begin
            sel = ex_data;
        end else if (mem_wen && (mem_rd == src)) begin
            sel = mem_data;
        end else if (wb_wen && (wb_rd == src)) begin
            sel = wb_data;
        end
        return sel;
    endfunction

endpackage

// File: rtl/of_scoreboard.sv
// Busy bits for destinations of in-flight long-latency ops, with a two-source query.
module of_scoreboard
    import of_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_idx,
    input  logic [ADDR_W-1:0] q1_idx,
    input  logic [ADDR_W-1:0] q2_idx,
    output logic              busy1_c,
    output logic              busy2_c
);

    localparam int unsigned N_REGS = 2**ADDR_W;

    logic [N_REGS-1:0] busy_q;
    logic [N_REGS-1:0] busy_nxt;

    // Set applied after clear so a same-index new issue wins over a retirement.
    always_comb begin
        busy_nxt = busy_q;
        if (clr_en) begin
            busy_nxt[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[set_idx] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    // A retirement in the current cycle releases its waiter immediately.
    always_comb begin
        busy1_c = (q1_idx != ADDR_W'(0)) && busy_q[q1_idx] && !(clr_en && (clr_idx == q1_idx));
        busy2_c = (q2_idx != ADDR_W'(0)) && busy_q[q2_idx] && !(clr_en && (clr_idx == q2_idx));
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads the register bank, bypasses EX/MEM/WB, stalls on load-use and busy long ops.
module operand_fetch
    import of_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_wen,
    input  logic              in_long,
    output logic [ADDR_W-1:0] read_reg1,
    output logic [ADDR_W-1:0] read_reg2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic              ex_wen,
    input  logic              ex_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              mem_wen,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wreg,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              long_done,
    input  logic [ADDR_W-1:0] long_rd,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_wen,
    output logic              out_long
);

    of_req_t           req_c;
    logic [DATA_W-1:0] rs1_sel_c;
    logic [DATA_W-1:0] rs2_sel_c;
    logic              busy1_c;
    logic              busy2_c;
    logic              load_use_c;
    logic              hazard_c;
    logic              accept_c;
    logic              sb_set_c;

    logic              out_valid_q;
    logic [DATA_W-1:0] rs1_q;
    logic [DATA_W-1:0] rs2_q;
    logic [ADDR_W-1:0] rd_q;
    logic              wen_q;
    logic              long_q;

    assign req_c = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, wen: in_wen, is_long: in_long};

    assign read_reg1 = req_c.rs1;
    assign read_reg2 = req_c.rs2;

    assign rs1_sel_c = bypass_sel(req_c.rs1, read_data1, ex_wen, ex_load, ex_rd, ex_data,
                                  mem_wen, mem_rd, mem_data, wreg, write_reg, write_data);
    assign rs2_sel_c = bypass_sel(req_c.rs2, read_data2, ex_wen, ex_load, ex_rd, ex_data,
                                  mem_wen, mem_rd, mem_data, wreg, write_reg, write_data);

    // A load in EX has no data yet, so a dependent instruction must wait a cycle.
    always_comb begin
        load_use_c = 1'b0;
        if (ex_wen && ex_load && (ex_rd != REG_ZERO)) begin
            load_use_c = (ex_rd == req_c.rs1) || (ex_rd == req_c.rs2);
        end
    end

    assign hazard_c = load_use_c || busy1_c || busy2_c;
    assign in_ready = !hazard_c && (!out_valid_q || out_ready) && !flush;
    assign accept_c = in_valid && in_ready;

    // Busy is marked when a long op hands off to execute, not when it enters this stage.
    assign sb_set_c = out_valid_q && out_ready && long_q && wen_q && !flush && (rd_q != REG_ZERO);

    of_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_en  (sb_set_c),
        .set_idx (rd_q),
        .clr_en  (long_done),
        .clr_idx (long_rd),
        .q1_idx  (req_c.rs1),
        .q2_idx  (req_c.rs2),
        .busy1_c (busy1_c),
        .busy2_c (busy2_c)
    );

    // Output register: loads on accept, holds under backpressure, flush kills it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wen_q       <= 1'b0;
            long_q      <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept_c) begin
            out_valid_q <= 1'b1;
            rs1_q       <= rs1_sel_c;
            rs2_q       <= rs2_sel_c;
            rd_q        <= req_c.rd;
            wen_q       <= req_c.wen;
            long_q      <= req_c.is_long;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = rs1_q;
    assign out_rs2_data = rs2_q;
    assign out_rd       = rd_q;
    assign out_wen      = wen_q;
    assign out_long     = long_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized checks of operand_fetch against a behavioural stage model.
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wen, in_long;
    logic [4:0]  read_reg1, read_reg2;
    logic [31:0] read_data1, read_data2;
    logic        ex_wen, ex_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        mem_wen;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wreg;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        long_done;
    logic [4:0]  long_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [4:0]  out_rd;
    logic        out_wen, out_long;

    logic [31:0] rf [32];
    assign read_data1 = rf[read_reg1];
    assign read_data2 = rf[read_reg2];

    always #5 clock = ~clock;

    operand_fetch dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .in_long(in_long),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .ex_wen(ex_wen), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
        .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
        .wreg(wreg), .write_reg(write_reg), .write_data(write_data),
        .long_done(long_done), .long_rd(long_rd),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_long(out_long)
    );

    // Reference state: what execute should see, plus the set of registers owned by long ops.
    bit          m_valid;
    logic [31:0] m_d1, m_d2;
    logic [4:0]  m_rd;
    bit          m_wen, m_long;
    bit          m_busy [32];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] s, input logic [31:0] bank);
        if (s == 5'd0) return 32'd0;
        if (ex_wen && !ex_load && ex_rd == s) return ex_data;
        if (mem_wen && mem_rd == s) return mem_data;
        if (wreg && write_reg == s) return write_data;
        return bank;
    endfunction

    function automatic bit ref_blocked(input logic [4:0] s);
        if (s == 5'd0) return 1'b0;
        if (ex_wen && ex_load && ex_rd == s) return 1'b1;
        return m_busy[s] && !(long_done && long_rd == s);
    endfunction

    function automatic bit ref_ready();
        return !ref_blocked(in_rs1) && !ref_blocked(in_rs2) && (!m_valid || out_ready) && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_d1 = '0; m_d2 = '0; m_rd = '0; m_wen = 0; m_long = 0;
        foreach (m_busy[i]) m_busy[i] = 0;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_wen = 0; in_long = 0;
        ex_wen = 0; ex_load = 0; ex_rd = '0; ex_data = '0;
        mem_wen = 0; mem_rd = '0; mem_data = '0;
        wreg = 0; write_reg = '0; write_data = '0;
        long_done = 0; long_rd = '0; flush = 0; out_ready = 1;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        bit acc, issue;
        logic [31:0] n1, n2;
        #2;
        chk("in_ready", 32'(in_ready), 32'(ref_ready()));
        chk("read_reg1", 32'(read_reg1), 32'(in_rs1));
        chk("read_reg2", 32'(read_reg2), 32'(in_rs2));
        acc   = in_valid && ref_ready();
        issue = m_valid && out_ready && m_long && m_wen && !flush && m_rd != 5'd0;
        n1 = ref_operand(in_rs1, rf[in_rs1]);
        n2 = ref_operand(in_rs2, rf[in_rs2]);
        if (long_done) m_busy[long_rd] = 0;
        if (issue) m_busy[m_rd] = 1;
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_d1 = n1; m_d2 = n2; m_rd = in_rd; m_wen = in_wen; m_long = in_long;
        end else if (m_valid && out_ready) m_valid = 0;
        @(posedge clock);
        #1;
        if (wreg && write_reg != 5'd0) rf[write_reg] = write_data;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_rs1_data", out_rs1_data, m_d1);
        chk("out_rs2_data", out_rs2_data, m_d2);
        chk("out_rd", 32'(out_rd), 32'(m_rd));
        chk("out_wen", 32'(out_wen), 32'(m_wen));
        chk("out_long", 32'(out_long), 32'(m_long));
    endtask

    logic [31:0] held1, held2;

    initial begin
        foreach (rf[i]) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[5] = 32'h11;
        idle();
        model_reset();
        reset = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_rs1", out_rs1_data, 32'd0);
        chk("rst_rs2", out_rs2_data, 32'd0);
        chk("rst_rd_wen_long", {27'd0, out_rd, out_wen, out_long} >> 0, 32'd0);
        @(posedge clock);
        #1;
        reset = 1;

        // Plain read, x0 reads zero even though the bank holds junk there
        in_valid = 1; in_rs1 = 5'd5; in_rs2 = 5'd0; in_rd = 5'd1; in_wen = 1;
        cycle();
        chk("tp_read_rs1", out_rs1_data, 32'h11);
        chk("tp_read_rs2", out_rs2_data, 32'h0);

        // Bypass priority EX > MEM > WB
        ex_wen = 1; ex_rd = 5'd5; ex_data = 32'hAA; mem_wen = 1; mem_rd = 5'd5; mem_data = 32'hBB;
        cycle();
        chk("tp_byp_ex", out_rs1_data, 32'hAA);
        ex_wen = 0;
        cycle();
        chk("tp_byp_mem", out_rs1_data, 32'hBB);
        mem_wen = 0; wreg = 1; write_reg = 5'd5; write_data = 32'hCC;
        cycle();
        chk("tp_byp_wb", out_rs1_data, 32'hCC);

        // Load-use stall, then the load result arrives from MEM
        idle();
        in_valid = 1; in_rs1 = 5'd0; in_rs2 = 5'd7; in_rd = 5'd2;
        ex_wen = 1; ex_load = 1; ex_rd = 5'd7;
        #1;
        chk("tp_load_use_stall", 32'(in_ready), 32'd0);
        cycle();
        ex_wen = 0; ex_load = 0; mem_wen = 1; mem_rd = 5'd7; mem_data = 32'h1234;
        cycle();
        chk("tp_load_use_fwd", out_rs2_data, 32'h1234);

        // Long op to x9 issues, dependent waits until retirement
        idle();
        in_valid = 1; in_rd = 5'd9; in_wen = 1; in_long = 1;
        cycle();
        idle();
        cycle();
        in_valid = 1; in_rs1 = 5'd9; in_rd = 5'd3; in_wen = 1;
        #1;
        chk("tp_long_stall", 32'(in_ready), 32'd0);
        cycle();
        cycle();
        long_done = 1; long_rd = 5'd9; wreg = 1; write_reg = 5'd9; write_data = 32'h55;
        #1;
        chk("tp_long_release", 32'(in_ready), 32'd1);
        cycle();
        chk("tp_long_data", out_rs1_data, 32'h55);
        long_done = 0; wreg = 0;
        #1;
        chk("tp_busy_cleared", 32'(in_ready), 32'd1);
        cycle();
        chk("tp_after_retire", out_rs1_data, 32'h55);

        // Backpressure hold, then flush; busy from a prior long op survives the flush
        idle();
        in_valid = 1; in_rd = 5'd13; in_wen = 1; in_long = 1;
        cycle();
        idle();
        cycle();
        in_valid = 1; in_rs1 = 5'd2; in_rs2 = 5'd5; in_rd = 5'd3; in_wen = 1;
        cycle();
        held1 = out_rs1_data; held2 = out_rs2_data;
        out_ready = 0; in_rs1 = 5'd4;
        for (int k = 0; k < 3; k++) begin
            ex_wen = 1; ex_rd = 5'd2; ex_data = $urandom;
            #1;
            chk("tp_hold_ready", 32'(in_ready), 32'd0);
            cycle();
            chk("tp_hold_rs1", out_rs1_data, held1);
            chk("tp_hold_rs2", out_rs2_data, held2);
        end
        ex_wen = 0; flush = 1;
        cycle();
        chk("tp_flush_valid", 32'(out_valid), 32'd0);
        flush = 0; out_ready = 1; in_rs1 = 5'd13;
        #1;
        chk("tp_flush_keeps_busy", 32'(in_ready), 32'd0);

        // Asynchronous reset in the middle of that stall
        #1;
        reset = 0;
        model_reset();
        #1;
        chk("tp_arst_valid", 32'(out_valid), 32'd0);
        chk("tp_arst_busy", 32'(in_ready), 32'd1);
        @(posedge clock);
        #1;
        chk("tp_arst_hold", 32'(out_valid), 32'd0);
        reset = 1;
        idle();
        long_done = 1; long_rd = 5'd13;
        cycle();
        idle();
        in_valid = 1; in_rs1 = 5'd0; in_rs2 = 5'd13; ex_wen = 1; ex_rd = 5'd0; ex_data = 32'hFFFF;
        #1;
        chk("tp_x0_no_stall", 32'(in_ready), 32'd1);
        cycle();
        chk("tp_x0_zero", out_rs1_data, 32'd0);

        // Randomized traffic on a small register window to force collisions
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_rs1     = 5'($urandom_range(0, 7));
            in_rs2     = 5'($urandom_range(0, 7));
            in_rd      = 5'($urandom_range(0, 7));
            in_wen     = ($urandom_range(0, 4) != 0);
            in_long    = ($urandom_range(0, 3) == 0);
            ex_wen     = 1'($urandom_range(0, 1));
            ex_load    = ($urandom_range(0, 3) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_data    = $urandom;
            mem_wen    = 1'($urandom_range(0, 1));
            mem_rd     = 5'($urandom_range(0, 7));
            mem_data   = $urandom;
            long_done  = ($urandom_range(0, 4) == 0);
            long_rd    = 5'($urandom_range(0, 7));
            wreg       = long_done ? 1'b1 : 1'($urandom_range(0, 1));
            write_reg  = long_done ? long_rd : 5'($urandom_range(0, 7));
            write_data = $urandom;
            flush      = ($urandom_range(0, 19) == 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Pipeline stage directly upstream of the register bank consumer (execute); drives the register bank read ports.
- Accepts decoded instructions and reads rs1/rs2 from the register bank.
- Resolves RAW hazards by bypassing from EX, MEM and write-back, plus a busy scoreboard for long-latency ops (mul/div).
- Registers the operands toward execute over a valid/ready handshake.

Parameters:
- DATA_W, 32, operand/register width
- ADDR_W, 5, register index width; the register file has 2**ADDR_W entries, and x0 is hardwired zero

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2, in_rd  in  ADDR_W each  source/destination indices
- in_wen  in  1  instruction writes rd
- in_long  in  1  instruction is long-latency (mul/div)
- read_reg1, read_reg2  out  ADDR_W  to register bank (combinational = in_rs1/in_rs2)
- read_data1, read_data2  in  DATA_W  from register bank (combinational read)
- ex_wen, ex_load  in  1 each  EX stage writes rd / EX op is a load
- ex_rd  in  ADDR_W;  ex_data  in  DATA_W
- mem_wen  in  1;  mem_rd  in  ADDR_W;  mem_data  in  DATA_W
- wreg  in  1;  write_reg  in  ADDR_W;  write_data  in  DATA_W  (write-back port, shared with register bank)
- long_done  in  1;  long_rd  in  ADDR_W  long op retired (its write appears on wreg the same cycle)
- flush  in  1  kill stage contents and input
- out_valid  out  1;  out_ready  in  1
- out_rs1_data, out_rs2_data  out  DATA_W;  out_rd  out  ADDR_W;  out_wen, out_long  out  1

Behaviour:
- Reset (reset=0, async): out_valid=0, out_rs1_data=0, out_rs2_data=0, out_rd=0, out_wen=0, out_long=0, busy vector=0.
- Operand select, per source, first match wins:
  - index==0 -> 0
  - ex_wen && !ex_load && ex_rd==src -> ex_data
  - mem_wen && mem_rd==src -> mem_data
  - wreg && write_reg==src -> write_data
  - otherwise register bank read_data.
- ex_wen/mem_wen/wreg with rd==0 never match.
- Hazard (combinational) when either source is nonzero and:
  - matches ex_rd with ex_wen && ex_load (load-use), or
  - busy[src]=1 and not (long_done && long_rd==src).
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept = in_valid && in_ready. Latency 1: operands and rd/wen/long are registered on accept and out_valid=1 next cycle.
- Output regs hold stable while out_valid && !out_ready. Held operands are never re-sampled; by construction they are final.
- out_valid clears on out_valid && out_ready && !accept.
- flush: next cycle out_valid=0; the input is not accepted; flush dominates accept and out handshake.
- Scoreboard (2**ADDR_W bits, bit 0 constant 0):
  - Set busy[out_rd] on out_valid && out_ready && out_long && out_wen && !flush && out_rd!=0.
  - Clear busy[long_rd] on long_done.
  - Same-index set and clear in one cycle -> set wins (new issue).
  - flush does not clear busy; already-issued long ops still retire.
- Reset mid-operation: all state returns to reset values immediately; pending long_done pulses after reset are ignored (clearing a 0 bit).

Decomposition:
- Package of_pkg holds DATA_W/ADDR_W defaults, the REG_ZERO constant, and an of_req_t struct {rs1, rs2, rd, wen, long}.
- Sub-module of_scoreboard (busy vector, set/clear, busy query for two sources) is natural.
- Bypass mux is a function in of_pkg, instanced twice.

Test Plan:
- Reg bank x5=0x11, no hazards, in_rs1=5, in_rs2=0, out_ready=1 -> next cycle out_valid=1, out_rs1_data=0x11, out_rs2_data=0.
- ex_wen=1, ex_load=0, ex_rd=5, ex_data=0xAA; mem_wen=1, mem_rd=5, mem_data=0xBB; in_rs1=5 -> out_rs1_data=0xAA (EX priority). Same with ex_wen=0 -> 0xBB. wreg=1, write_reg=5, write_data=0xCC only -> 0xCC.
- ex_wen=1, ex_load=1, ex_rd=7; in_rs2=7 -> in_ready=0 for that cycle. Next cycle mem_rd=7, mem_data=0x1234 -> accepted, out_rs2_data=0x1234.
- Issue long op rd=9 (out handshake); next instruction rs1=9 stalls. long_done=1, long_rd=9, wreg=1, write_reg=9, write_data=0x55 -> accepted that cycle, out_rs1_data=0x55, busy[9]=0.
- out_valid=1, out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then flush=1 -> out_valid=0 next cycle, busy unchanged.
- Assert reset=0 asynchronously mid-stall -> out_valid=0 and busy=0 without a clock edge. ex_wen=1, ex_rd=0, in_rs1=0 -> out_rs1_data=0, no stall.
